// File: rtl/dmem_ctrl.sv
// dmem_ctrl: multi-cycle data-memory controller and M/L two-way arbiter
//    Sequences one read or write at a time through a fixed-latency, single-ported
//    memory. Out-of-range accesses are answered with an error and never reach it.
//    Optional feature macro DMEM_RR_EN: round-robin tie-break (default: M wins).
//    Parameters: LAT (memory latency, 1..15), MEM_BYTES (memory size in bytes)
//    Ports:
//       clk_i, reset_i              clock, synchronous active-high reset
//       m_req_i/m_we_i/m_addr_i/m_wdata_i   memory-stage request (held until ack)
//       m_ack_o/m_rdata_o/m_err_o   memory-stage one-cycle response, data/err held
//       m_stall_o                   m_req_i && !m_ack_o
//       l_*                         loader/debug port, same rules as M (no stall)
//       mem_re_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_rdata_i   memory port
module dmem_ctrl #(
   parameter int LAT       = 3,
   parameter int MEM_BYTES = 8192
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        m_req_i,
   input  logic        m_we_i,
   input  logic [63:0] m_addr_i,
   input  logic [63:0] m_wdata_i,
   output logic        m_ack_o,
   output logic [63:0] m_rdata_o,
   output logic        m_err_o,
   output logic        m_stall_o,
   input  logic        l_req_i,
   input  logic        l_we_i,
   input  logic [63:0] l_addr_i,
   input  logic [63:0] l_wdata_i,
   output logic        l_ack_o,
   output logic [63:0] l_rdata_o,
   output logic        l_err_o,
   output logic        mem_re_o,
   output logic        mem_we_o,
   output logic [63:0] mem_addr_o,
   output logic [63:0] mem_wdata_o,
   input  logic [63:0] mem_rdata_i
);
   localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2;
   // addr + 8 <= MEM_BYTES rewritten so it cannot overflow near the top of the range
   localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);
   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d, gnt_q, gnt_d;
   logic [63:0] addr_q, addr_d, wdata_q, wdata_d;
   logic [63:0] m_rdata_q, m_rdata_d, l_rdata_q, l_rdata_d;
   logic        m_err_q, m_err_d, l_err_q, l_err_d;
   logic        pick_l, sel_we, legal, busy;
   logic [63:0] sel_addr, sel_wdata, resp_rdata;
`ifdef DMEM_RR_EN
   logic        last_q, last_d;
   // last_q = 1 means L was granted last, so M wins the next tie
   assign pick_l = l_req_i && (!m_req_i || !last_q);
`else
   assign pick_l = l_req_i && !m_req_i;
`endif
   assign sel_we     = pick_l ? l_we_i : m_we_i;
   assign sel_addr   = pick_l ? l_addr_i : m_addr_i;
   assign sel_wdata  = pick_l ? l_wdata_i : m_wdata_i;
   assign legal      = !sel_addr[63] && sel_addr <= ADDR_MAX;
   assign busy       = state_q == BUSY;
   assign resp_rdata = we_q ? '0 : mem_rdata_i;
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      we_d      = we_q;
      gnt_d     = gnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      m_rdata_d = m_rdata_q;
      l_rdata_d = l_rdata_q;
      m_err_d   = m_err_q;
      l_err_d   = l_err_q;
`ifdef DMEM_RR_EN
      last_d    = last_q;
`endif
      if (state_q == IDLE && (m_req_i || l_req_i)) begin
         state_d = legal ? BUSY : RESP;
         cnt_d   = 4'(LAT - 1);
         we_d    = sel_we;
         gnt_d   = pick_l;
         addr_d  = sel_addr;
         wdata_d = sel_wdata;
`ifdef DMEM_RR_EN
         last_d  = pick_l;
`endif
         // response registers load on entry to RESP so they change exactly with ack
         if (!legal && pick_l) begin
            l_rdata_d = '0;
            l_err_d   = 1'b1;
         end else if (!legal) begin
            m_rdata_d = '0;
            m_err_d   = 1'b1;
         end
      end else if (busy) begin
         cnt_d = cnt_q - 4'd1;
         if (cnt_q == 4'd0 && gnt_q) begin
            state_d   = RESP;
            l_rdata_d = resp_rdata;
            l_err_d   = 1'b0;
         end else if (cnt_q == 4'd0) begin
            state_d   = RESP;
            m_rdata_d = resp_rdata;
            m_err_d   = 1'b0;
         end
      end else if (state_q == RESP) begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         we_q      <= 1'b0;
         gnt_q     <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         m_rdata_q <= '0;
         l_rdata_q <= '0;
         m_err_q   <= 1'b0;
         l_err_q   <= 1'b0;
`ifdef DMEM_RR_EN
         last_q    <= 1'b1;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         we_q      <= we_d;
         gnt_q     <= gnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         m_rdata_q <= m_rdata_d;
         l_rdata_q <= l_rdata_d;
         m_err_q   <= m_err_d;
         l_err_q   <= l_err_d;
`ifdef DMEM_RR_EN
         last_q    <= last_d;
`endif
      end
   end
   assign m_ack_o     = state_q == RESP && !gnt_q;
   assign l_ack_o     = state_q == RESP && gnt_q;
   assign m_rdata_o   = m_rdata_q;
   assign l_rdata_o   = l_rdata_q;
   assign m_err_o     = m_err_q;
   assign l_err_o     = l_err_q;
   assign m_stall_o   = m_req_i && !m_ack_o;
   assign mem_re_o    = busy && !we_q;
   assign mem_we_o    = busy && we_q;
   assign mem_addr_o  = busy ? addr_q : '0;
   assign mem_wdata_o = busy ? wdata_q : '0;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: self-checking bench for dmem_ctrl (table vectors, corner sequences, random vs model)
module tb_dmem_ctrl;
   localparam int LAT = 3;
   localparam int MEM_BYTES = 8192;
   typedef struct {
      bit          port;
      bit          we;
      logic [63:0] addr;
      logic [63:0] wdata;
      bit          err;
      logic [63:0] rd;
   } vec_t;
   logic clk = 1'b0, reset = 1'b1;
   always #5 clk = ~clk;
   logic        m_req = 1'b0, m_we = 1'b0, l_req = 1'b0, l_we = 1'b0;
   logic [63:0] m_addr = '0, m_wdata = '0, l_addr = '0, l_wdata = '0;
   logic        m_ack, m_err, m_stall, l_ack, l_err, mem_re, mem_we;
   logic [63:0] m_rdata, l_rdata, mem_addr, mem_wdata;
   logic [63:0] mem_rdata = '0;
   logic        m_req1 = 1'b0;
   logic        m_ack1, m_err1, m_stall1, l_ack1, l_err1, mem_re1, mem_we1;
   logic [63:0] m_rdata1, l_rdata1, mem_addr1, mem_wdata1;
   logic [63:0] mem_rdata1 = 64'hA5A5_0001;
   dmem_ctrl #(.LAT(LAT), .MEM_BYTES(MEM_BYTES)) u_dut (
      .clk_i(clk), .reset_i(reset),
      .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
      .m_ack_o(m_ack), .m_rdata_o(m_rdata), .m_err_o(m_err), .m_stall_o(m_stall),
      .l_req_i(l_req), .l_we_i(l_we), .l_addr_i(l_addr), .l_wdata_i(l_wdata),
      .l_ack_o(l_ack), .l_rdata_o(l_rdata), .l_err_o(l_err),
      .mem_re_o(mem_re), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata));
   dmem_ctrl #(.LAT(1), .MEM_BYTES(MEM_BYTES)) u_lat1 (
      .clk_i(clk), .reset_i(reset),
      .m_req_i(m_req1), .m_we_i(1'b0), .m_addr_i(64'h10), .m_wdata_i(64'h0),
      .m_ack_o(m_ack1), .m_rdata_o(m_rdata1), .m_err_o(m_err1), .m_stall_o(m_stall1),
      .l_req_i(1'b0), .l_we_i(1'b0), .l_addr_i(64'h0), .l_wdata_i(64'h0),
      .l_ack_o(l_ack1), .l_rdata_o(l_rdata1), .l_err_o(l_err1),
      .mem_re_o(mem_re1), .mem_we_o(mem_we1), .mem_addr_o(mem_addr1),
      .mem_wdata_o(mem_wdata1), .mem_rdata_i(mem_rdata1));
   // memory: data is only valid in the LAT-th consecutive read cycle, garbage otherwise
   logic [63:0] phys_mem [longint];
   int re_run = 0;
   always @(posedge clk) if (mem_we) phys_mem[longint'(mem_addr)] = mem_wdata;
   always @(negedge clk) begin
      re_run = mem_re ? re_run + 1 : 0;
      if (re_run == LAT)
         mem_rdata = phys_mem.exists(longint'(mem_addr)) ? phys_mem[longint'(mem_addr)] : '0;
      else
         mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
   end
   int total = 0, bad = 0;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      reset = 1'b1;
      m_req = 1'b0;
      l_req = 1'b0;
      m_req1 = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
   endtask
   task automatic drive(input int p, input logic r, input logic w, input logic [63:0] a, input logic [63:0] d);
      if (p == 1) begin
         l_req = r; l_we = w; l_addr = a; l_wdata = d;
      end else begin
         m_req = r; m_we = w; m_addr = a; m_wdata = d;
      end
   endtask
   task automatic single(input vec_t v, output int lat, output int re_n, output int we_n,
                         output int st_n, output int oth_n, output logic [63:0] rd,
                         output logic er, output logic [63:0] ad, output logic [63:0] wd);
      bit done = 0;
      lat = 0; re_n = 0; we_n = 0; st_n = 0; oth_n = 0;
      rd = '1; er = 1'b0; ad = '0; wd = '0;
      drive(int'(v.port), 1'b1, v.we, v.addr, v.wdata);
      while (!done && lat < 40) begin
         @(negedge clk);
         re_n += int'(mem_re);
         we_n += int'(mem_we);
         st_n += int'(m_stall);
         oth_n += int'(v.port ? m_ack : l_ack);
         if (mem_re || mem_we) ad = mem_addr;
         if (mem_we) wd = mem_wdata;
         if (v.port ? l_ack : m_ack) begin
            done = 1;
            rd = v.port ? l_rdata : m_rdata;
            er = v.port ? l_err : m_err;
         end
         tick();
         if (!done) lat++;
      end
      m_req = 1'b0;
      l_req = 1'b0;
   endtask
   task automatic run_vec(input string tag, input vec_t v);
      int lat, re_n, we_n, st_n, oth_n, el;
      logic [63:0] rd, ad, wd;
      logic er;
      bit ok;
      single(v, lat, re_n, we_n, st_n, oth_n, rd, er, ad, wd);
      el = v.err ? 1 : LAT + 1;
      ok = !v.err;
      chk({tag, " latency"}, 64'(lat), 64'(el));
      chk({tag, " re cycles"}, 64'(re_n), 64'((ok && !v.we) ? LAT : 0));
      chk({tag, " we cycles"}, 64'(we_n), 64'((ok && v.we) ? LAT : 0));
      chk({tag, " stall cycles"}, 64'(st_n), 64'(v.port ? 0 : el));
      chk({tag, " other ack"}, 64'(oth_n), 64'd0);
      chk({tag, " rdata"}, rd, v.rd);
      chk({tag, " err"}, 64'(er), 64'(v.err));
      chk({tag, " mem_addr"}, ad, ok ? v.addr : 64'd0);
      chk({tag, " mem_wdata"}, wd, (ok && v.we) ? v.wdata : 64'd0);
   endtask
   vec_t vecs [0:10];
   logic [63:0] atab [0:9];
   logic [63:0] ref_mem [longint];
   task automatic rand_run(input int ncyc);
      bit pend [2];
      bit busy = 0, cur = 0, cur_we = 0, cur_ok = 0, pl, e_mack, e_lack, e_en;
`ifdef DMEM_RR_EN
      bit last = 1;
`endif
      int gc = 0, ac = 0;
      logic [63:0] cur_addr = '0, cur_wd = '0, cur_rd = '0;
      logic [63:0] hold_rd [2];
      logic hold_err [2];
      pend[0] = 0; pend[1] = 0;
      hold_rd[0] = '0; hold_rd[1] = '0;
      hold_err[0] = 0; hold_err[1] = 0;
      for (int c = 0; c < ncyc; c++) begin
         for (int p = 0; p < 2; p++) begin
            if (!pend[p]) begin
               drive(p, 1'b0, 1'b0, '0, '0);
               if ($urandom_range(0, 2) == 0) begin
                  pend[p] = 1;
                  drive(p, 1'b1, 1'($urandom_range(0, 1)), atab[$urandom_range(0, 9)],
                        {$urandom, $urandom});
               end
            end else if (busy && int'(cur) == p) begin
               if ($urandom_range(0, 3) == 0)
                  drive(p, p == 1 ? l_req : m_req, 1'($urandom_range(0, 1)),
                        atab[$urandom_range(0, 9)], {$urandom, $urandom});
               if ($urandom_range(0, 7) == 0) begin
                  if (p == 1) l_req = 1'b0;
                  else m_req = 1'b0;
               end
            end
         end
         e_mack = busy && c == ac && !cur;
         e_lack = busy && c == ac && cur;
         e_en = busy && cur_ok && c > gc && c <= gc + LAT;
         if (busy && c == ac) begin
            hold_rd[cur] = cur_rd;
            hold_err[cur] = !cur_ok;
         end
         @(negedge clk);
         chk("rand ack/stall/enables", 64'({m_ack, l_ack, m_stall, mem_re, mem_we}),
             64'({e_mack, e_lack, m_req && !e_mack, e_en && !cur_we, e_en && cur_we}));
         chk("rand m_rdata", m_rdata, hold_rd[0]);
         chk("rand l_rdata", l_rdata, hold_rd[1]);
         chk("rand err", 64'({m_err, l_err}), 64'({hold_err[0], hold_err[1]}));
         if (e_en) chk("rand mem_addr", mem_addr, cur_addr);
         if (e_en && cur_we) chk("rand mem_wdata", mem_wdata, cur_wd);
         if (busy && c == ac) begin
            busy = 0;
            pend[cur] = 0;
         end else if (!busy && (m_req || l_req)) begin
`ifdef DMEM_RR_EN
            pl = l_req && (!m_req || !last);
            last = pl;
`else
            pl = l_req && !m_req;
`endif
            cur = pl;
            cur_we = pl ? l_we : m_we;
            cur_addr = pl ? l_addr : m_addr;
            cur_wd = pl ? l_wdata : m_wdata;
            cur_ok = !cur_addr[63] && ({1'b0, cur_addr} + 65'd8 <= 65'(MEM_BYTES));
            busy = 1;
            gc = c;
            ac = cur_ok ? c + LAT + 1 : c + 1;
            cur_rd = (!cur_ok || cur_we) ? '0 :
                     (ref_mem.exists(longint'(cur_addr)) ? ref_mem[longint'(cur_addr)] : '0);
            if (cur_ok && cur_we) ref_mem[longint'(cur_addr)] = cur_wd;
         end
         tick();
      end
      m_req = 1'b0;
      l_req = 1'b0;
   endtask
   initial begin
      int n, lat, acks;
      logic [63:0] rd;
      bit done;
      int order [$];
      vecs[0]  = '{1'b0, 1'b0, 64'h100, 64'h0, 1'b0, 64'hDEADBEEF};
      vecs[1]  = '{1'b1, 1'b1, 64'h40, 64'h1234, 1'b0, 64'h0};
      vecs[2]  = '{1'b0, 1'b0, 64'h40, 64'h0, 1'b0, 64'h1234};
      vecs[3]  = '{1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 1'b1, 64'h0};
      vecs[4]  = '{1'b0, 1'b0, 64'(MEM_BYTES - 4), 64'h0, 1'b1, 64'h0};
      vecs[5]  = '{1'b1, 1'b0, 64'(MEM_BYTES - 8), 64'h0, 1'b0, 64'hCAFE};
      vecs[6]  = '{1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFC, 64'h0, 1'b1, 64'h0};
      vecs[7]  = '{1'b0, 1'b1, 64'h100, 64'h55, 1'b0, 64'h0};
      vecs[8]  = '{1'b1, 1'b0, 64'h100, 64'h0, 1'b0, 64'h55};
      vecs[9]  = '{1'b0, 1'b0, 64'(MEM_BYTES), 64'h0, 1'b1, 64'h0};
      vecs[10] = '{1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'h99, 1'b1, 64'h0};
      atab[0] = 64'h0;   atab[1] = 64'h8;   atab[2] = 64'h40;  atab[3] = 64'h100;
      atab[4] = 64'h1F8; atab[5] = 64'(MEM_BYTES - 8);
      atab[6] = 64'hFFFF_FFFF_FFFF_FFF8; atab[7] = 64'(MEM_BYTES - 4);
      atab[8] = 64'h7FFF_FFFF_FFFF_FFFC; atab[9] = 64'h40;
      phys_mem[64'h100] = 64'hDEADBEEF;
      phys_mem[longint'(MEM_BYTES - 8)] = 64'hCAFE;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset flags", 64'({m_ack, l_ack, m_err, l_err, mem_re, mem_we, m_stall}), 64'd0);
      chk("reset m_rdata", m_rdata, 64'd0);
      chk("reset l_rdata", l_rdata, 64'd0);
      chk("reset mem_addr", mem_addr, 64'd0);
      chk("reset mem_wdata", mem_wdata, 64'd0);
      tick();
      reset = 1'b0;
      for (int i = 0; i <= 10; i++) run_vec($sformatf("vec%0d", i), vecs[i]);
      // LAT = 1 instance: one enable cycle, ack two cycles after the request
      m_req1 = 1'b1;
      n = 0; lat = 0; done = 0; rd = '1;
      while (!done && lat < 20) begin
         @(negedge clk);
         n += int'(mem_re1);
         if (m_ack1) begin
            done = 1;
            rd = m_rdata1;
         end
         tick();
         if (!done) lat++;
      end
      m_req1 = 1'b0;
      chk("lat1 latency", 64'(lat), 64'd2);
      chk("lat1 re cycles", 64'(n), 64'd1);
      chk("lat1 rdata", rd, 64'hA5A5_0001);
      // reset in the second BUSY cycle abandons the access
      drive(0, 1'b1, 1'b0, 64'h100, 64'h0);
      tick();
      tick();
      @(negedge clk);
      chk("rst mid re before", 64'(mem_re), 64'd1);
      reset = 1'b1;
      m_req = 1'b0;
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("rst mid enables after", 64'({mem_re, mem_we}), 64'd0);
      acks = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         acks += int'(m_ack) + int'(l_ack);
      end
      chk("rst mid no ack", 64'(acks), 64'd0);
      tick();
      run_vec("after reset", '{1'b0, 1'b0, 64'h100, 64'h0, 1'b0, 64'h55});
      // both requesters held continuously
      do_reset();
      drive(0, 1'b1, 1'b0, 64'h100, 64'h0);
      drive(1, 1'b1, 1'b0, 64'h40, 64'h0);
      for (int i = 0; i < 60 && order.size() < 4; i++) begin
         @(negedge clk);
         if (m_ack && l_ack) order.push_back(2);
         else if (m_ack) order.push_back(0);
         else if (l_ack) order.push_back(1);
         tick();
      end
      m_req = 1'b0;
      l_req = 1'b0;
      chk("tie grant count", 64'(order.size()), 64'd4);
      for (int i = 0; i < 4; i++)
`ifdef DMEM_RR_EN
         chk($sformatf("tie grant %0d", i), 64'(i < order.size() ? order[i] : 9), 64'(i % 2));
`else
         chk($sformatf("tie grant %0d", i), 64'(i < order.size() ? order[i] : 9), 64'd0);
`endif
      do_reset();
      phys_mem.delete();
      ref_mem.delete();
      rand_run(4000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
